// File: rtl/mem_pkg.sv
// Shared sizes and port FSM state encoding for the line-granular main memory.
package mem_pkg;
  localparam int FETCH_SIZE = 64;
  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_SIZE  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RDATA = 2'd2,
    WCAP  = 2'd3
  } portState_e;
endpackage

// File: rtl/line_mem_port.sv
// One memory port: request sampling, fixed-latency sequencing, read snapshot buffer
// and the tri-state line bus driver. The array itself lives in the parent.
module line_mem_port
  import mem_pkg::*;
#(
  parameter int LATENCY   = 3,
  parameter int LINE_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readM,
  input  logic                  writeM,
  input  logic [ADDR_SIZE-1:0]  addressM,
  inout  wire  [FETCH_SIZE-1:0] dataM,
  input  logic [FETCH_SIZE-1:0] rdLine,
  output logic                  busy,
  output logic                  drop,
  output logic [LINE_BITS-1:0]  rdIdx,
  output logic                  snap,
  output logic [LINE_BITS-1:0]  wrIdx,
  output logic                  wrEn,
  output logic [FETCH_SIZE-1:0] wrData
);
  portState_e            state_r, nextState_s;
  logic [1:0]            cnt_r;
  logic [LINE_BITS-1:0]  lineIdx_r;
  logic                  isWrite_r;
  logic                  busy_r;
  logic                  drive_r;
  logic [FETCH_SIZE-1:0] rdBuf_r;
  logic                  start_s, snap_s, wrEn_s, drop_s;
  logic                  unusedAddr_s;

  // Next-state and per-cycle strobes; unknown request levels fall through as idle
  always_comb begin
    nextState_s = state_r;
    start_s     = 1'b0;
    snap_s      = 1'b0;
    wrEn_s      = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (readM & writeM) begin
          drop_s = 1'b1;
        end else if (readM | writeM) begin
          start_s     = 1'b1;
          nextState_s = WAIT;
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        drop_s = readM | writeM;
        if (cnt_r == 2'(LATENCY - 1)) begin
          if (isWrite_r) begin
            nextState_s = WCAP;
          end else begin
            nextState_s = RDATA;
            snap_s      = 1'b1;
          end
        end else begin
          nextState_s = WAIT;
        end
      end
      RDATA: begin
        drop_s      = readM | writeM;
        nextState_s = IDLE;
      end
      WCAP: begin
        drop_s      = readM | writeM;
        wrEn_s      = 1'b1;
        nextState_s = IDLE;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State, latency counter, latched request and read snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 2'd0;
      lineIdx_r <= '0;
      isWrite_r <= 1'b0;
      busy_r    <= 1'b0;
      drive_r   <= 1'b0;
      rdBuf_r   <= 64'd0;
    end else begin
      state_r <= nextState_s;
      busy_r  <= (nextState_s != IDLE);
      drive_r <= (nextState_s == RDATA);
      if (start_s) begin
        lineIdx_r <= addressM[LINE_BITS+1:2];
        isWrite_r <= writeM;
        cnt_r     <= 2'd1;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + 2'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (snap_s) begin
        rdBuf_r <= rdLine;
      end else begin
        rdBuf_r <= rdBuf_r;
      end
    end
  end

  assign dataM        = drive_r ? rdBuf_r : {FETCH_SIZE{1'bz}};
  assign unusedAddr_s = ^{addressM[ADDR_SIZE-1:LINE_BITS+2], addressM[1:0]};
  assign busy         = busy_r;
  assign drop         = drop_s;
  assign rdIdx        = lineIdx_r;
  assign snap         = snap_s;
  assign wrIdx        = lineIdx_r;
  assign wrEn         = wrEn_s;
  assign wrData       = dataM;
endmodule

// File: rtl/line_memory.sv
// Dual-port (I, D) line memory: word-organised array shared by two port sequencers;
// same-line writes in the same cycle resolve in favour of the D port.
module line_memory
  import mem_pkg::*;
#(
  parameter int    LATENCY   = 3,
  parameter int    LINE_BITS = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_readM,
  input  logic                  i_writeM,
  input  logic [ADDR_SIZE-1:0]  i_addressM,
  inout  wire  [FETCH_SIZE-1:0] i_dataM,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  input  logic [ADDR_SIZE-1:0]  d_addressM,
  inout  wire  [FETCH_SIZE-1:0] d_dataM,
  output logic                  i_busy,
  output logic                  d_busy,
  output logic                  d_err
);
  localparam int DEPTH_WORDS = LINE_WORDS * (2 ** LINE_BITS);

  logic [WORD_SIZE-1:0]  mem_r [0:DEPTH_WORDS-1];
  logic [LINE_BITS-1:0]  iRdIdx_s, iWrIdx_s, dRdIdx_s, dWrIdx_s;
  logic [FETCH_SIZE-1:0] iRdLine_s, dRdLine_s, iWrData_s, dWrData_s;
  logic                  iSnap_s, dSnap_s, iWrEn_s, dWrEn_s, iDrop_s, dDrop_s;
  logic                  iWrKeep_s;
  logic                  dErr_r;
  logic                  unusedStrobes_s;

  line_mem_port #(.LATENCY(LATENCY), .LINE_BITS(LINE_BITS)) uPortI (
    .clk(clk), .reset(reset), .readM(i_readM), .writeM(i_writeM),
    .addressM(i_addressM), .dataM(i_dataM), .rdLine(iRdLine_s),
    .busy(i_busy), .drop(iDrop_s), .rdIdx(iRdIdx_s), .snap(iSnap_s),
    .wrIdx(iWrIdx_s), .wrEn(iWrEn_s), .wrData(iWrData_s)
  );

  line_mem_port #(.LATENCY(LATENCY), .LINE_BITS(LINE_BITS)) uPortD (
    .clk(clk), .reset(reset), .readM(d_readM), .writeM(d_writeM),
    .addressM(d_addressM), .dataM(d_dataM), .rdLine(dRdLine_s),
    .busy(d_busy), .drop(dDrop_s), .rdIdx(dRdIdx_s), .snap(dSnap_s),
    .wrIdx(dWrIdx_s), .wrEn(dWrEn_s), .wrData(dWrData_s)
  );

  // Word 0 of a line sits in the least-significant 16 bits of the line bus
  assign iRdLine_s = {mem_r[{iRdIdx_s, 2'd3}], mem_r[{iRdIdx_s, 2'd2}],
                      mem_r[{iRdIdx_s, 2'd1}], mem_r[{iRdIdx_s, 2'd0}]};
  assign dRdLine_s = {mem_r[{dRdIdx_s, 2'd3}], mem_r[{dRdIdx_s, 2'd2}],
                      mem_r[{dRdIdx_s, 2'd1}], mem_r[{dRdIdx_s, 2'd0}]};
  assign iWrKeep_s = iWrEn_s & ~(dWrEn_s & (dWrIdx_s == iWrIdx_s));
  assign unusedStrobes_s = iSnap_s ^ dSnap_s ^ iDrop_s;

  // Line write commit; the array is deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (iWrKeep_s) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        mem_r[{iWrIdx_s, 2'(w)}] <= iWrData_s[w*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (dWrEn_s) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        mem_r[{dWrIdx_s, 2'(w)}] <= dWrData_s[w*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Sticky record of any dropped D-port request
  always_ff @(posedge clk) begin
    if (reset) begin
      dErr_r <= 1'b0;
    end else if (dDrop_s) begin
      dErr_r <= 1'b1;
    end else begin
      dErr_r <= dErr_r;
    end
  end

  assign d_err = dErr_r;
endmodule

// File: tb/tb_line_memory.sv
// Directed self-checking bench for line_memory (LATENCY=3, LINE_BITS=10).
module tb_line_memory;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_readM = 1'b0, i_writeM = 1'b0;
  logic        d_readM = 1'b0, d_writeM = 1'b0;
  logic [15:0] i_addressM = 16'h0000, d_addressM = 16'h0000;
  logic [63:0] tbDataI = 64'd0, tbDataD = 64'd0;
  logic        tbDrvI = 1'b0, tbDrvD = 1'b0;
  wire  [63:0] i_dataM, d_dataM;
  logic        i_busy, d_busy, d_err;
  int          checks = 0, errors = 0;
  logic [63:0] rd;

  localparam logic [63:0] LINE5 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] BEEF  = 64'hDEAD_BEEF_CAFE_F00D;

  assign i_dataM = tbDrvI ? tbDataI : 64'bz;
  assign d_dataM = tbDrvD ? tbDataD : 64'bz;

  line_memory #(.LATENCY(3), .LINE_BITS(10), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .i_readM(i_readM), .i_writeM(i_writeM), .i_addressM(i_addressM), .i_dataM(i_dataM),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_addressM(d_addressM), .d_dataM(d_dataM),
    .i_busy(i_busy), .d_busy(d_busy), .d_err(d_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic writeD(input logic [15:0] a, input logic [63:0] v);
    d_addressM = a; d_writeM = 1'b1; tick;
    d_writeM = 1'b0; d_addressM = 16'hFFFF; tick; tick;
    tbDataD = v; tbDrvD = 1'b1; tick;
    tbDrvD = 1'b0;
  endtask

  task automatic writeI(input logic [15:0] a, input logic [63:0] v);
    i_addressM = a; i_writeM = 1'b1; tick;
    i_writeM = 1'b0; i_addressM = 16'hFFFF; tick; tick;
    tbDataI = v; tbDrvI = 1'b1; tick;
    tbDrvI = 1'b0;
  endtask

  task automatic readD(input logic [15:0] a, output logic [63:0] v);
    d_addressM = a; d_readM = 1'b1; tick;
    d_readM = 1'b0; d_addressM = 16'hFFFF; tick; tick;
    v = d_dataM; tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; tick; reset = 1'b0;
    checks++; if (i_busy !== 1'b0) begin errors++; $display("FAIL reset_i_busy got %b want 0", i_busy); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_d_busy got %b want 0", d_busy); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL reset_d_err got %b want 0", d_err); end
  endtask

  task automatic test_read_timing;
    logic busyExp [4];
    logic validExp [4];
    busyExp  = '{1'b1, 1'b1, 1'b1, 1'b0};
    validExp = '{1'b0, 1'b0, 1'b1, 1'b0};
    writeD(16'h0014, LINE5);
    d_addressM = 16'h0014; d_readM = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick;
      d_readM = 1'b0; d_addressM = 16'hFFFF;
      checks++;
      if (d_busy !== busyExp[e]) begin
        errors++; $display("FAIL read_busy_E%0d got %b want %b", e, d_busy, busyExp[e]);
      end
      checks++;
      if ((d_dataM === LINE5) !== validExp[e]) begin
        errors++; $display("FAIL read_data_E%0d got %h valid_want %b", e, d_dataM, validExp[e]);
      end
    end
  endtask

  task automatic test_write_read;
    writeD(16'h0020, BEEF);
    readD(16'h0022, rd);
    checks++; if (rd !== BEEF) begin errors++; $display("FAIL write_read got %h want %h", rd, BEEF); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL write_read_err got %b want 0", d_err); end
  endtask

  task automatic test_dual_port;
    writeI(16'h0040, 64'hAAAA_0000_1111_2222);
    writeD(16'h0080, 64'h5555_6666_7777_8888);
    i_addressM = 16'h0040; d_addressM = 16'h0080; i_readM = 1'b1; d_readM = 1'b1;
    tick;
    i_readM = 1'b0; d_readM = 1'b0; tick; tick;
    checks++; if (i_dataM !== 64'hAAAA_0000_1111_2222) begin errors++; $display("FAIL dual_i got %h want %h", i_dataM, 64'hAAAA_0000_1111_2222); end
    checks++; if (d_dataM !== 64'h5555_6666_7777_8888) begin errors++; $display("FAIL dual_d got %h want %h", d_dataM, 64'h5555_6666_7777_8888); end
    tick;
    // Same-line writes at the same edge: D must win
    i_addressM = 16'h0030; d_addressM = 16'h0031; i_writeM = 1'b1; d_writeM = 1'b1;
    tick;
    i_writeM = 1'b0; d_writeM = 1'b0; tick; tick;
    tbDataI = 64'h1010_1010_1010_1010; tbDataD = 64'h2020_2020_2020_2020;
    tbDrvI = 1'b1; tbDrvD = 1'b1; tick;
    tbDrvI = 1'b0; tbDrvD = 1'b0;
    readD(16'h0030, rd);
    checks++; if (rd !== 64'h2020_2020_2020_2020) begin errors++; $display("FAIL same_line_d_wins got %h want %h", rd, 64'h2020_2020_2020_2020); end
  endtask

  task automatic test_busy_drop;
    d_addressM = 16'h0014; d_readM = 1'b1; tick;   // E0 sampled
    tick;                                          // E1: request held, dropped
    d_readM = 1'b0;
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL drop_err_set got %b want 1", d_err); end
    tick;                                          // E2: snapshot
    checks++; if (d_dataM !== LINE5) begin errors++; $display("FAIL drop_first_read got %h want %h", d_dataM, LINE5); end
    tick;                                          // E3
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL drop_busy_E3 got %b want 0", d_busy); end
    tick; tick;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL drop_no_second got %b want 0", d_busy); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL drop_err_sticky got %b want 1", d_err); end
  endtask

  task automatic test_conflict;
    reset = 1'b1; tick; reset = 1'b0;
    d_addressM = 16'h0014; d_readM = 1'b1; d_writeM = 1'b1; tick;
    d_readM = 1'b0; d_writeM = 1'b0;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL rw_conflict_busy got %b want 0", d_busy); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL rw_conflict_err got %b want 1", d_err); end
  endtask

  task automatic test_reset_abort;
    writeD(16'h0024, 64'h0000_0000_0000_1111);
    d_addressM = 16'h0024; d_writeM = 1'b1; tick;  // E0
    d_writeM = 1'b0; tick;                         // E1
    reset = 1'b1; tbDataD = 64'h9999_9999_9999_9999; tbDrvD = 1'b1;
    tick;                                          // E2 sees reset
    reset = 1'b0;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", d_busy); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL abort_err_cleared got %b want 0", d_err); end
    tick;
    tbDrvD = 1'b0; tick;
    readD(16'h0024, rd);
    checks++; if (rd !== 64'h0000_0000_0000_1111) begin errors++; $display("FAIL abort_line9 got %h want %h", rd, 64'h1111); end
  endtask

  task automatic test_alias_and_float;
    readD(16'h1014, rd);
    checks++; if (rd !== LINE5) begin errors++; $display("FAIL alias_line5 got %h want %h", rd, LINE5); end
    d_readM = 1'bz; d_addressM = 16'hzzzz; tick; tick;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL float_busy got %b want 0", d_busy); end
    checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL float_err got %b want 0", d_err); end
    d_readM = 1'b0; d_addressM = 16'h0000;
  endtask

  task automatic test_back_to_back;
    d_addressM = 16'h0014; d_readM = 1'b1; tick;   // E0
    d_readM = 1'b0; tick; tick;                    // E1, E2
    d_readM = 1'b1; tick;                          // E3: still finishing, dropped
    d_readM = 1'b0;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL b2b_E3_dropped got %b want 0", d_busy); end
    checks++; if (d_err !== 1'b1) begin errors++; $display("FAIL b2b_err got %b want 1", d_err); end
    d_readM = 1'b1; tick;                          // E4: accepted
    d_readM = 1'b0;
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL b2b_E4_accept got %b want 1", d_busy); end
    tick; tick;
    checks++; if (d_dataM !== LINE5) begin errors++; $display("FAIL b2b_data got %h want %h", d_dataM, LINE5); end
    tick;
  endtask

  initial begin
    test_reset;
    test_read_timing;
    test_write_read;
    test_dual_port;
    test_busy_drop;
    test_conflict;
    test_reset_abort;
    test_alias_and_float;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
